// File: rtl/msg_scheduler.sv
// Message line arbiter: per-source pending slots, fixed-priority selection,
// minimum hold time in seconds, and pre-emption by designated urgent sources.
module msg_scheduler #(
    parameter int unsigned N_REQ     = 8,
    parameter int unsigned SRC_W     = 3,
    parameter int unsigned ID_W      = 6,
    parameter int unsigned HOLD_SEC  = 5,
    parameter int unsigned PREEMPT_N = 2,
    parameter int unsigned IDLE_ID   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_1sec,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ID_W-1:0]   req_id,
    output logic [ID_W-1:0]         msg_id,
    output logic                    msg_valid,
    output logic                    new_msg,
    output logic [SRC_W-1:0]        active_src,
    output logic [N_REQ-1:0]        pending,
    output logic                    holding
);

    localparam logic [7:0]      HOLD_LIM = 8'(HOLD_SEC);
    localparam logic [ID_W-1:0] IDLE_VAL = ID_W'(IDLE_ID);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LINGER
    } state_t;

    state_t                       state, state_nxt;
    logic [N_REQ-1:0]             pend, pend_nxt;
    logic [N_REQ-1:0][ID_W-1:0]   pend_id, pend_id_nxt;
    logic [7:0]                   hold_cnt, hold_cnt_nxt;
    logic [ID_W-1:0]              msg_id_nxt;
    logic [SRC_W-1:0]             src_nxt;
    logic                         valid_nxt;
    logic                         new_nxt;
    logic                         holding_nxt;

    logic [SRC_W-1:0]             win;
    int unsigned                  win_idx;
    logic                         any_pend;
    logic                         can_preempt;
    logic                         do_load;

    // Lowest pending index wins; scanned high-to-low so the last hit is the lowest.
    always_comb begin
        win_idx  = 0;
        any_pend = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pend[N_REQ-1-i]) begin
                win_idx  = N_REQ - 1 - i;
                any_pend = 1'b1;
            end
        end
        win         = SRC_W'(win_idx);
        can_preempt = (win_idx < PREEMPT_N) && (win < active_src);
    end

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        pend_id_nxt  = pend_id;
        hold_cnt_nxt = hold_cnt;
        msg_id_nxt   = msg_id;
        src_nxt      = active_src;
        valid_nxt    = msg_valid;
        holding_nxt  = holding;
        new_nxt      = 1'b0;
        do_load      = 1'b0;

        case (state)
            ST_IDLE:   do_load = any_pend;
            ST_HOLD:   do_load = any_pend && can_preempt;
            ST_LINGER: do_load = any_pend;
            default:   do_load = 1'b0;
        endcase

        if (do_load) begin
            msg_id_nxt    = pend_id[win];
            src_nxt       = win;
            valid_nxt     = 1'b1;
            hold_cnt_nxt  = '0;
            holding_nxt   = 1'b1;
            new_nxt       = 1'b1;
            pend_nxt[win] = 1'b0;
            state_nxt     = ST_HOLD;
        end else if (state == ST_HOLD && tick_1sec) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
            if (hold_cnt_nxt == HOLD_LIM) begin
                holding_nxt = 1'b0;
                state_nxt   = ST_LINGER;
            end
        end

        // A same-edge request re-arms the slot even if it was just served.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                pend_nxt[i]    = 1'b1;
                pend_id_nxt[i] = req_id[i*ID_W +: ID_W];
            end
        end

        if (flush) begin
            pend_nxt     = '0;
            hold_cnt_nxt = '0;
            msg_id_nxt   = IDLE_VAL;
            src_nxt      = '0;
            valid_nxt    = 1'b0;
            holding_nxt  = 1'b0;
            new_nxt      = 1'b0;
            state_nxt    = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pend       <= '0;
            pend_id    <= '0;
            hold_cnt   <= '0;
            msg_id     <= IDLE_VAL;
            active_src <= '0;
            msg_valid  <= 1'b0;
            new_msg    <= 1'b0;
            holding    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend       <= pend_nxt;
            pend_id    <= pend_id_nxt;
            hold_cnt   <= hold_cnt_nxt;
            msg_id     <= msg_id_nxt;
            active_src <= src_nxt;
            msg_valid  <= valid_nxt;
            new_msg    <= new_nxt;
            holding    <= holding_nxt;
        end
    end

    assign pending = pend;

endmodule

// File: tb/tb_msg_scheduler.sv
// Bench for msg_scheduler: directed vector table, async reset check, and
// randomized traffic against a seconds-held reference model.
module tb_msg_scheduler;

    localparam int HOLD_SEC  = 5;
    localparam int PREEMPT_N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1sec = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  req = '0;
    logic [47:0] req_id = '0;
    logic [5:0]  msg_id;
    logic        msg_valid;
    logic        new_msg;
    logic [2:0]  active_src;
    logic [7:0]  pending;
    logic        holding;

    msg_scheduler #(
        .N_REQ(8), .SRC_W(3), .ID_W(6), .HOLD_SEC(HOLD_SEC),
        .PREEMPT_N(PREEMPT_N), .IDLE_ID(0)
    ) dut (
        .clk(clk), .rst(rst), .tick_1sec(tick_1sec), .flush(flush),
        .req(req), .req_id(req_id), .msg_id(msg_id), .msg_valid(msg_valid),
        .new_msg(new_msg), .active_src(active_src), .pending(pending),
        .holding(holding)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [5:0] eid, input bit ev,
                           input bit en, input logic [2:0] es, input logic [7:0] ep,
                           input bit eh);
        chk({tag, ".msg_id"},     64'(msg_id),     64'(eid));
        chk({tag, ".msg_valid"},  64'(msg_valid),  64'(ev));
        chk({tag, ".new_msg"},    64'(new_msg),    64'(en));
        chk({tag, ".active_src"}, 64'(active_src), 64'(es));
        chk({tag, ".pending"},    64'(pending),    64'(ep));
        chk({tag, ".holding"},    64'(holding),    64'(eh));
    endtask

    function automatic logic [47:0] rid(input int i, input logic [5:0] id);
        return 48'(id) << (i * 6);
    endfunction

    typedef struct {
        bit          t;
        bit          f;
        logic [7:0]  r;
        logic [47:0] rid;
        logic [5:0]  eid;
        bit          ev;
        bit          en;
        logic [2:0]  es;
        logic [7:0]  ep;
        bit          eh;
    } vec_t;

    vec_t vq[$];

    task automatic vec(input bit t, input bit f, input logic [7:0] r, input logic [47:0] ri,
                       input logic [5:0] eid, input bit ev, input bit en,
                       input logic [2:0] es, input logic [7:0] ep, input bit eh);
        vec_t v;
        v.t = t; v.f = f; v.r = r; v.rid = ri;
        v.eid = eid; v.ev = ev; v.en = en; v.es = es; v.ep = ep; v.eh = eh;
        vq.push_back(v);
    endtask

    // Reference model: what is shown and how many whole seconds it has been held.
    bit         m_pend[8];
    logic [5:0] m_pid[8];
    bit         m_shown;
    logic [5:0] m_id;
    int         m_src;
    int         m_secs;
    bit         m_new;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_pend[i] = 0; m_pid[i] = '0; end
        m_shown = 0; m_id = '0; m_src = 0; m_secs = 0; m_new = 0;
    endtask

    task automatic model_step(input bit t, input bit f, input logic [7:0] r, input logic [47:0] ri);
        int win;
        bit load;
        if (f) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
            m_shown = 0; m_id = '0; m_src = 0; m_secs = 0; m_new = 0;
            return;
        end
        win = -1;
        for (int i = 7; i >= 0; i--) if (m_pend[i]) win = i;
        load = 0;
        if (win >= 0) begin
            if (!m_shown || m_secs >= HOLD_SEC) load = 1;
            else if (win < PREEMPT_N && win < m_src) load = 1;
        end
        if (load) begin
            m_id = m_pid[win]; m_src = win; m_shown = 1; m_secs = 0; m_new = 1;
            m_pend[win] = 0;
        end else begin
            m_new = 0;
            if (m_shown && m_secs < HOLD_SEC && t) m_secs++;
        end
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin m_pend[i] = 1; m_pid[i] = ri[i*6 +: 6]; end
        end
    endtask

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_pend[i];
        return p;
    endfunction

    initial begin
        // t  f  req    req_id                        id     v  n  src  pend   hold
        vec(0, 0, 8'h08, rid(3, 6'h12),                6'h00, 0, 0, 3'd0, 8'h08, 0);
        vec(0, 0, 8'h00, '0,                           6'h12, 1, 1, 3'd3, 8'h00, 1);
        vec(0, 0, 8'h00, '0,                           6'h12, 1, 0, 3'd3, 8'h00, 1);
        vec(0, 0, 8'h02, rid(1, 6'h30),                6'h12, 1, 0, 3'd3, 8'h02, 1);
        vec(0, 0, 8'h00, '0,                           6'h30, 1, 1, 3'd1, 8'h00, 1);
        vec(0, 0, 8'h44, rid(2, 6'h21) | rid(6, 6'h26), 6'h30, 1, 0, 3'd1, 8'h44, 1);
        vec(0, 0, 8'h00, '0,                           6'h30, 1, 0, 3'd1, 8'h44, 1);
        repeat (4) vec(1, 0, 8'h00, '0,                6'h30, 1, 0, 3'd1, 8'h44, 1);
        vec(1, 0, 8'h00, '0,                           6'h30, 1, 0, 3'd1, 8'h44, 0);
        vec(0, 0, 8'h00, '0,                           6'h21, 1, 1, 3'd2, 8'h40, 1);
        vec(0, 1, 8'h01, rid(0, 6'h3F),                6'h00, 0, 0, 3'd0, 8'h00, 0);
        vec(0, 0, 8'h00, '0,                           6'h00, 0, 0, 3'd0, 8'h00, 0);
        vec(0, 0, 8'h20, rid(5, 6'h15),                6'h00, 0, 0, 3'd0, 8'h20, 0);
        vec(1, 0, 8'h00, '0,                           6'h15, 1, 1, 3'd5, 8'h00, 1);
        repeat (4) vec(1, 0, 8'h00, '0,                6'h15, 1, 0, 3'd5, 8'h00, 1);
        vec(1, 0, 8'h00, '0,                           6'h15, 1, 0, 3'd5, 8'h00, 0);
        vec(0, 0, 8'h20, rid(5, 6'h16),                6'h15, 1, 0, 3'd5, 8'h20, 0);
        vec(0, 0, 8'h20, rid(5, 6'h17),                6'h16, 1, 1, 3'd5, 8'h20, 1);
        vec(0, 0, 8'h00, '0,                           6'h16, 1, 0, 3'd5, 8'h20, 1);
        repeat (4) vec(1, 0, 8'h00, '0,                6'h16, 1, 0, 3'd5, 8'h20, 1);
        vec(1, 0, 8'h00, '0,                           6'h16, 1, 0, 3'd5, 8'h20, 0);
        vec(0, 0, 8'h00, '0,                           6'h17, 1, 1, 3'd5, 8'h00, 1);
        vec(1, 0, 8'h00, '0,                           6'h17, 1, 0, 3'd5, 8'h00, 1);
        vec(1, 0, 8'h40, rid(6, 6'h2A),                6'h17, 1, 0, 3'd5, 8'h40, 1);
        repeat (2) vec(1, 0, 8'h00, '0,                6'h17, 1, 0, 3'd5, 8'h40, 1);
        vec(1, 0, 8'h00, '0,                           6'h17, 1, 0, 3'd5, 8'h40, 0);
        vec(0, 0, 8'h00, '0,                           6'h2A, 1, 1, 3'd6, 8'h00, 1);
        vec(0, 0, 8'h06, rid(1, 6'h2A) | rid(2, 6'h2A), 6'h2A, 1, 0, 3'd6, 8'h06, 1);
        // Same ID as the one shown still produces a strobe.
        vec(0, 0, 8'h00, '0,                           6'h2A, 1, 1, 3'd1, 8'h04, 1);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 6'h00, 0, 0, 3'd0, 8'h00, 0);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            tick_1sec = vq[i].t; flush = vq[i].f; req = vq[i].r; req_id = vq[i].rid;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vq[i].eid, vq[i].ev, vq[i].en,
                    vq[i].es, vq[i].ep, vq[i].eh);
        end
        tick_1sec = 0; flush = 0; req = '0; req_id = '0;

        // Asynchronous reset mid-HOLD must take effect before the next clock edge.
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 6'h00, 0, 0, 3'd0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int c = 0; c < 600; c++) begin
            logic [63:0] rnd;
            logic [7:0]  r;
            bit          t, f;
            rnd = {$urandom(), $urandom()};
            r = 8'($urandom()) & 8'($urandom()) & 8'($urandom());
            t = ($urandom_range(3) == 0);
            f = ($urandom_range(39) == 0);
            tick_1sec = t; flush = f; req = r; req_id = rnd[47:0];
            model_step(t, f, r, rnd[47:0]);
            @(negedge clk);
            chk_all($sformatf("rnd%0d", c), m_id, m_shown, m_new, 3'(m_src),
                    m_pend_vec(), m_shown && (m_secs < HOLD_SEC));
        end
        tick_1sec = 0; flush = 0; req = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/msg_scheduler.md
Name: msg_scheduler

Overview:
- Arbitrates the single 60-character taunt/status line among event sources: module mistakes, timer warnings, state-change chatter and random filler.
- Holds each shown message for a minimum number of seconds and queues at most one pending message per source.
- Lets designated urgent sources pre-empt a lower-priority message that is still being held.
- Outputs a message ID and a one-cycle new-message strobe; the ID drives the downstream ASCII message ROM and the display writer.

Parameters:
- N_REQ, 8, number of requesters; index 0 = highest priority.
- SRC_W, 3, width of the source index (ceil(log2(N_REQ))).
- ID_W, 6, width of a message ID.
- HOLD_SEC, 5, minimum display time in tick_1sec pulses (1..255).
- PREEMPT_N, 2, requesters with index < PREEMPT_N may pre-empt.
- IDLE_ID, 0, ID driven when nothing is shown.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tick_1sec  in  1  one-cycle pulse, once per second
- flush  in  1  one-cycle pulse: drop everything (game state change)
- req  in  N_REQ  per-source one-cycle request pulse
- req_id  in  N_REQ*ID_W  message ID of source i, bits [i*ID_W +: ID_W]; sampled only when req[i]=1
- msg_id  out  ID_W  current message ID
- msg_valid  out  1  a message is currently shown
- new_msg  out  1  one-cycle pulse, first cycle a newly loaded ID is on msg_id
- active_src  out  SRC_W  index of the source currently shown; 0 when idle
- pending  out  N_REQ  per-source pending flags
- holding  out  1  hold time not yet expired

Behaviour:
- Reset (async, rst=0) values:
  - msg_id=IDLE_ID, msg_valid=0, new_msg=0, active_src=0, pending=0, holding=0.
  - All pending ID slots=0, hold_cnt=0, state=IDLE.
- Pending capture:
  - On each edge with req[i]=1, pend[i] is set and pend_id[i] is loaded from req_id[i].
  - A newer request overwrites an unserved one (last one wins).
- Selection (combinational, from registered pend only):
  - win = lowest index with pend set.
  - Requests arriving on edge k are eligible for loading on edge k+1.
- States:
  - IDLE: no message shown. If any pend is set, LOAD on the next edge.
  - HOLD: message shown and hold_cnt < HOLD_SEC. Each tick_1sec increments hold_cnt. When hold_cnt reaches HOLD_SEC, go to LINGER. In HOLD, LOAD happens only on pre-emption.
  - LINGER: hold expired; the message stays displayed. Any pend set -> LOAD on the next edge.
- LOAD (one edge):
  - msg_id <= pend_id[win]; active_src <= win; msg_valid <= 1; hold_cnt <= 0; holding <= 1.
  - Clear pend[win], unless req[win]=1 on the same edge: then pend stays set and pend_id takes the new ID.
  - Enter HOLD. new_msg=1 for exactly the cycle following the LOAD edge.
  - new_msg pulses even when the new ID equals the old ID.
- Pre-emption:
  - Applies in HOLD only, when win < PREEMPT_N and win < active_src.
  - The pre-empted message is discarded, not re-queued.
  - A source never pre-empts itself or an equal- or higher-priority source.
- Hold timing:
  - The first tick after LOAD counts as one full second, so real display time is in (HOLD_SEC-1, HOLD_SEC] seconds.
  - When tick_1sec coincides with LOAD, hold_cnt=0; that tick is not counted.
- flush:
  - Takes priority over req, LOAD and tick on the same edge; same-edge requests are dropped.
  - Clears all pend, sets msg_valid=0, msg_id=IDLE_ID, active_src=0, holding=0, and enters IDLE.
  - new_msg is not pulsed.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Expected size: ~150-250 lines of RTL.

Test Plan:
- Reset, then req[3]=1 with id 0x12 at edge k.
  - pending[3]=1 after k.
  - At k+1: msg_id=0x12, active_src=3, msg_valid=1; new_msg=1 for one cycle; pending[3]=0.
- HOLD_SEC=5; show src 4, then req[5] at the 2nd tick.
  - Src 5 stays pending through ticks 3 and 4.
  - Loaded one edge after the 5th tick, with new_msg pulsing.
- Showing src 4 in HOLD, req[1]=1 with id 0x30.
  - Next edge: msg_id=0x30, active_src=1, hold_cnt restarts.
  - With req[2] instead: no pre-emption; it waits for LINGER.
- req[6] and req[2] on the same edge while IDLE.
  - Src 2 loads first; pending[6] stays 1.
  - Src 6 loads 5 ticks later.
- LINGER with src 4 shown (pending=0), then req[4] with id 0x07.
  - Loads next edge; new_msg=1; msg_id=0x07.
- HOLD with pending=0b0110_0000, flush asserted together with req[0].
  - Next edge: pending=0, msg_valid=0, msg_id=0, no new_msg, state IDLE.
  - Assert rst low mid-HOLD: all outputs return to reset values immediately.
